// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC definitions: datapath width, divider FSM states and the
// control-bundle bit positions that select the div/mod ops.
package tinyrisc_pkg;

    localparam int TINYRISC_XLEN = 32;

    // 22-bit decoded control bundle carried through ID/EX
    localparam int CTRL_W       = 22;
    localparam int CTRL_DIV_BIT = 20;
    localparam int CTRL_MOD_BIT = 21;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic ctrl_is_divmod(input ctrl_word_t ctrl);
        return ctrl[CTRL_DIV_BIT] | ctrl[CTRL_MOD_BIT];
    endfunction

endpackage

// File: rtl/ex_divider.sv
// EX-stage iterative signed divider (restoring, one bit per cycle) that stalls
// the front of the pipe while busy. Optional divide-by-zero trap: TINYRISC_DIVZERO_TRAP_EN.
module ex_divider
    import tinyrisc_pkg::*;
#(
    parameter int WIDTH = TINYRISC_XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mod,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef TINYRISC_DIVZERO_TRAP_EN
    ,
    output logic             div_zero
`endif
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_is_mod;

    logic             w_go;
    logic             w_accept;
    logic             w_trap;
    logic             w_step;
    logic             w_last;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_signed;
    logic [WIDTH-1:0] w_rem_signed;
    logic [WIDTH-1:0] w_final;

    // Operand conditioning: work on magnitudes, restore signs at the end.
    assign w_dvs_zero = (divisor == '0);
    assign w_dvd_mag  = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign w_dvs_mag  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

    assign w_go = (r_state == IDLE) && start && !flush;
`ifdef TINYRISC_DIVZERO_TRAP_EN
    assign w_trap   = w_go && w_dvs_zero;
`else
    assign w_trap   = 1'b0;
`endif
    assign w_accept = w_go && !w_trap;
    assign w_step   = (r_state == CALC) && !flush;
    assign w_last   = (r_cnt == LAST_STEP);

    // Restoring step: shift in the next dividend bit, keep the trial if it did not go negative.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    assign w_quo_signed = r_q_neg ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;
    assign w_rem_signed = r_r_neg ? (~w_rem_nxt + WIDTH'(1)) : w_rem_nxt;
    assign w_final      = r_is_mod ? w_rem_signed : w_quo_signed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trap) begin
                    w_state_nxt = DONE;
                end else if (w_accept) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gated by rst_n so a start held high during reset cannot raise stall.
    assign stall  = rst_n && (w_accept || (r_state == CALC));
    assign result = r_result;

    // NOTE: the datapath is reset along with the FSM, so result reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvs    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_is_mod <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_dvs    <= w_dvs_mag;
                r_quo    <= w_dvd_mag;
                r_rem    <= '0;
                r_cnt    <= '0;
                // Divide-by-zero keeps the all-ones quotient regardless of signs.
                r_q_neg  <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && !w_dvs_zero;
                r_r_neg  <= dividend[WIDTH-1];
                r_is_mod <= is_mod;
            end else if (w_step) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_final;
                end
            end
            if (w_trap) begin
                r_result <= '0;
            end
        end
    end

`ifdef TINYRISC_DIVZERO_TRAP_EN
    logic r_div_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_zero <= 1'b0;
        end else if (w_trap) begin
            r_div_zero <= 1'b1;
        end else if (r_state == DONE) begin
            r_div_zero <= 1'b0;
        end
    end

    assign div_zero = r_div_zero;
`endif

endmodule

// File: tb/tb_ex_divider.sv
// Directed self-checking bench for ex_divider: signed div/mod vectors, latency,
// stall shape, flush abort, mid-operation reset and the divide-by-zero behaviour.
module tb_ex_divider;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        is_mod   = 1'b0;
    logic        flush    = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor  = '0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef TINYRISC_DIVZERO_TRAP_EN
    logic        div_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ex_divider dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_mod   (is_mod),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef TINYRISC_DIVZERO_TRAP_EN
        ,
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left just after a rising edge; start is presented in cycle 0.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic stall_bad;
        logic exp_stall;
        lat       = -1;
        stall_bad = 1'b0;
        exp_stall = (exp_lat != 1);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_mod    = m;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (stall !== exp_stall) stall_bad = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stall_shape"}, {31'd0, stall_bad}, 32'd0);
        check({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
`ifdef TINYRISC_DIVZERO_TRAP_EN
        check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, (exp_lat == 1)});
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_result_held"}, result, exp_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] prev;
        logic        seen_done;

        #12;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("div_100_7",   32'd100,        32'd7,          1'b0, 32'd14,         33);
        run_op("mod_100_7",   32'd100,        32'd7,          1'b1, 32'd2,          33);
        run_op("mod_m100_7",  32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFFE,  33);
        run_op("div_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  33);
        run_op("mod_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'd1,          33);
        run_op("div_m7_m2",   32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0, 32'd3,          33);
        run_op("div_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  33);
        run_op("mod_min_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          33);
`ifdef TINYRISC_DIVZERO_TRAP_EN
        run_op("div_55_0",    32'd55,         32'd0,          1'b0, 32'd0,          1);
`else
        run_op("div_55_0",    32'd55,         32'd0,          1'b0, 32'hFFFF_FFFF,  33);
        run_op("mod_55_0",    32'd55,         32'd0,          1'b1, 32'd55,         33);
`endif
        run_op("div_12345_1", 32'd12345,      32'd1,          1'b0, 32'd12345,      33);

        // start together with flush in IDLE must be ignored
        start    = 1'b1;
        flush    = 1'b1;
        dividend = 32'd40;
        divisor  = 32'd5;
        is_mod   = 1'b0;
        @(negedge clk);
        check("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // flush during the 10th CALC cycle aborts without a done pulse
        prev      = result;
        seen_done = 1'b0;
        start     = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        @(negedge clk);
        check("flush_c0_stall", {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("flush_c10_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        if (done) seen_done = 1'b1;
        check("flush_no_done", {31'd0, seen_done}, 32'd0);
        check("flush_next_stall", {31'd0, stall}, 32'd0);
        check("flush_next_busy", {31'd0, busy}, 32'd0);
        check("flush_result_kept", result, prev);
        @(posedge clk);
        #1;
        run_op("b2b_1000_3", 32'd1000, 32'd3, 1'b0, 32'd333, 33);

        // asynchronous reset in the 20th CALC cycle
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd7;
        is_mod   = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
